// File: rtl/uart_buffered.sv
// uart_buffered: memory-mapped UART with TX and RX FIFOs.
//
// Ports
//   clk        - system clock, all state on the rising edge
//   resetn     - asynchronous active-low reset
//   rx         - serial receive line (idle high, asynchronous to clk)
//   tx         - serial transmit line (idle high)
//   read/write - single-cycle bus strobes
//   address    - byte address; a 16-byte window at BASE_ADDRESS
//                (0x0 DATA, 0x4 STATUS, 0x8 CTRL, 0xC DIVISOR)
//   write_data - bus write data
//   read_data  - combinational read data, zero when not reading
//   irq        - registered level interrupt request

// Small synchronous FIFO used for both directions. A pop frees a slot, so
// a push in the same cycle is accepted even when the FIFO is full.
module uart_buffered_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end
endmodule

module uart_buffered #(
    parameter int          CLOCK_FREQ   = 25000000,
    parameter int          BIT_RATE     = 9600,
    parameter int          PAYLOAD_BITS = 8,
    parameter int          BUFFER_SIZE  = 8,
    parameter logic [31:0] BASE_ADDRESS = 32'h00001000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rx,
    output logic        tx,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        irq
);
    localparam logic [15:0] RESET_DIVISOR = 16'(CLOCK_FREQ / BIT_RATE);
    localparam int          IDX_W         = $clog2(PAYLOAD_BITS);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(PAYLOAD_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;

    // Register window decode
    logic       sel;
    logic [1:0] offset;
    logic       data_wr, data_rd, status_wr, ctrl_wr, div_wr;
    logic       unused_bus;

    assign sel        = (address[31:4] == BASE_ADDRESS[31:4]);
    assign offset     = address[3:2];
    assign data_wr    = write && sel && (offset == 2'd0);
    assign status_wr  = write && sel && (offset == 2'd1);
    assign ctrl_wr    = write && sel && (offset == 2'd2);
    assign div_wr     = write && sel && (offset == 2'd3);
    assign data_rd    = read  && sel && (offset == 2'd0);
    assign unused_bus = ^{address[1:0], write_data[31:16]};

    // CTRL: 0 TX_EN, 1 RX_EN, 2 PAR_EN, 3 PAR_ODD, 4 STOP2, 5 RX_IE, 6 TX_IE
    logic [6:0]  ctrl;
    logic [15:0] divisor;
    logic        rx_ovf, frame_err, parity_err, tx_ovf;
    logic        rx_ovf_set, frame_err_set, parity_err_set, tx_ovf_set;
    logic [3:0]  status_clr;

    // FIFO hookup
    logic [PAYLOAD_BITS-1:0] tx_head, rx_head, rx_word;
    logic tx_empty, tx_full, tx_pop;
    logic rx_empty, rx_full, rx_pop, rx_valid;

    assign rx_pop = data_rd && !rx_empty;

    uart_buffered_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(BUFFER_SIZE)) u_tx_fifo (
        .clk(clk), .resetn(resetn), .push(data_wr), .pop(tx_pop),
        .push_data(write_data[PAYLOAD_BITS-1:0]), .head(tx_head),
        .empty(tx_empty), .full(tx_full)
    );

    uart_buffered_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(BUFFER_SIZE)) u_rx_fifo (
        .clk(clk), .resetn(resetn), .push(rx_valid), .pop(rx_pop),
        .push_data(rx_word), .head(rx_head),
        .empty(rx_empty), .full(rx_full)
    );

    // A write or received byte is dropped only if no pop frees a slot that cycle.
    assign tx_ovf_set = data_wr && tx_full && !tx_pop;
    assign rx_ovf_set = rx_valid && rx_full && !rx_pop;
    assign status_clr = status_wr ? write_data[8:5] : 4'b0;

    // ---------------- Transmitter ----------------
    uart_state_t             tx_state, tx_next;
    logic [15:0]             tx_count, tx_div;
    logic [IDX_W-1:0]        tx_index;
    logic [PAYLOAD_BITS-1:0] tx_shift;
    logic                    tx_parity, tx_par_en, tx_stop2, tx_second_stop;
    logic                    tx_line, tx_bit_end, tx_busy;

    assign tx_bit_end = (tx_count == tx_div - 16'd1);
    assign tx_busy    = (tx_state != IDLE);
    assign tx         = tx_line;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) tx_state <= IDLE;
        else         tx_state <= tx_next;
    end

    // TX_EN is only looked at in IDLE, so clearing it lets a frame finish.
    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        case (tx_state)
            IDLE:   if (ctrl[0] && !tx_empty) begin
                        tx_pop  = 1'b1;
                        tx_next = START;
                    end
            START:  if (tx_bit_end) tx_next = DATA;
            DATA:   if (tx_bit_end && tx_index == LAST_BIT)
                        tx_next = tx_par_en ? PARITY : STOP;
            PARITY: if (tx_bit_end) tx_next = STOP;
            STOP:   if (tx_bit_end && (tx_second_stop || !tx_stop2)) tx_next = IDLE;
            default: tx_next = IDLE;
        endcase
    end

    // Frame format and divisor are captured at frame start; tx_line is
    // registered and always carries the bit of the current state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_count       <= '0;
            tx_div         <= RESET_DIVISOR;
            tx_index       <= '0;
            tx_shift       <= '0;
            tx_parity      <= 1'b0;
            tx_par_en      <= 1'b0;
            tx_stop2       <= 1'b0;
            tx_second_stop <= 1'b0;
            tx_line        <= 1'b1;
        end else if (tx_state == IDLE) begin
            tx_count <= '0;
            if (tx_pop) begin
                tx_shift       <= tx_head;
                tx_parity      <= (^tx_head) ^ ctrl[3];
                tx_div         <= divisor;
                tx_index       <= '0;
                tx_par_en      <= ctrl[2];
                tx_stop2       <= ctrl[4];
                tx_second_stop <= 1'b0;
                tx_line        <= 1'b0;
            end
        end else begin
            tx_count <= tx_bit_end ? 16'd0 : tx_count + 16'd1;
            if (tx_bit_end) begin
                case (tx_state)
                    START: tx_line <= tx_shift[0];
                    DATA: begin
                        tx_index <= tx_index + IDX_W'(1);
                        tx_shift <= tx_shift >> 1;
                        if (tx_index == LAST_BIT) tx_line <= tx_par_en ? tx_parity : 1'b1;
                        else                      tx_line <= tx_shift[1];
                    end
                    PARITY: tx_line <= 1'b1;
                    STOP: begin
                        tx_second_stop <= 1'b1;
                        tx_line        <= 1'b1;
                    end
                    default: tx_line <= 1'b1;
                endcase
            end
        end
    end

    // ---------------- Receiver ----------------
    uart_state_t             rx_state, rx_next;
    logic                    rx_meta, rx_sync, rx_prev, rx_fall;
    logic [15:0]             rx_count, rx_div;
    logic [IDX_W-1:0]        rx_index;
    logic [PAYLOAD_BITS-1:0] rx_shift;
    logic                    rx_par_en, rx_par_odd, rx_par_bit, rx_parity_ok, rx_sample;

    // Edge detection needs rx_prev high, so after a framing error the
    // receiver cannot re-arm until the line has returned high.
    assign rx_fall      = rx_prev && !rx_sync;
    assign rx_sample    = (rx_state == START) ? (rx_count == (rx_div >> 1) - 16'd1)
                                              : (rx_count == rx_div - 16'd1);
    assign rx_parity_ok = !rx_par_en || (rx_par_bit == ((^rx_shift) ^ rx_par_odd));
    assign rx_word      = rx_shift;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= IDLE;
        end else begin
            rx_meta  <= rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_state <= rx_next;
        end
    end

    always_comb begin
        rx_next        = rx_state;
        rx_valid       = 1'b0;
        frame_err_set  = 1'b0;
        parity_err_set = 1'b0;
        case (rx_state)
            IDLE:   if (rx_fall && ctrl[1]) rx_next = START;
            START:  if (rx_sample) rx_next = rx_sync ? IDLE : DATA;
            DATA:   if (rx_sample && rx_index == LAST_BIT)
                        rx_next = rx_par_en ? PARITY : STOP;
            PARITY: if (rx_sample) rx_next = STOP;
            STOP:   if (rx_sample) begin
                        rx_next        = IDLE;
                        frame_err_set  = !rx_sync;
                        parity_err_set = rx_sync && !rx_parity_ok;
                        rx_valid       = rx_sync && rx_parity_ok;
                    end
            default: rx_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_count   <= '0;
            rx_div     <= RESET_DIVISOR;
            rx_index   <= '0;
            rx_shift   <= '0;
            rx_par_en  <= 1'b0;
            rx_par_odd <= 1'b0;
            rx_par_bit <= 1'b0;
        end else if (rx_state == IDLE) begin
            rx_count <= '0;
            if (rx_fall && ctrl[1]) begin
                rx_div     <= divisor;
                rx_index   <= '0;
                rx_par_en  <= ctrl[2];
                rx_par_odd <= ctrl[3];
            end
        end else begin
            rx_count <= rx_sample ? 16'd0 : rx_count + 16'd1;
            if (rx_sample && rx_state == DATA) begin
                rx_shift <= {rx_sync, rx_shift[PAYLOAD_BITS-1:1]};
                rx_index <= rx_index + IDX_W'(1);
            end
            if (rx_sample && rx_state == PARITY) rx_par_bit <= rx_sync;
        end
    end

    // ---------------- Registers and interrupt ----------------
    // Sticky flags: a set event in the same cycle beats a clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctrl       <= 7'h03;
            divisor    <= RESET_DIVISOR;
            rx_ovf     <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            tx_ovf     <= 1'b0;
            irq        <= 1'b0;
        end else begin
            if (ctrl_wr) ctrl <= write_data[6:0];
            if (div_wr)  divisor <= (write_data[15:0] < 16'd16) ? 16'd16 : write_data[15:0];
            rx_ovf     <= rx_ovf_set     || (rx_ovf     && !status_clr[0]);
            frame_err  <= frame_err_set  || (frame_err  && !status_clr[1]);
            parity_err <= parity_err_set || (parity_err && !status_clr[2]);
            tx_ovf     <= tx_ovf_set     || (tx_ovf     && !status_clr[3]);
            irq        <= (ctrl[5] && !rx_empty) || (ctrl[6] && tx_empty && !tx_busy)
                          || rx_ovf || frame_err || parity_err;
        end
    end

    always_comb begin
        read_data = '0;
        if (read && sel) begin
            case (offset)
                2'd0: if (!rx_empty) read_data[PAYLOAD_BITS-1:0] = rx_head;
                2'd1: read_data[8:0] = {tx_ovf, parity_err, frame_err, rx_ovf, tx_busy,
                                        tx_full, tx_empty, rx_full, !rx_empty};
                2'd2: read_data[6:0] = ctrl;
                default: read_data[15:0] = divisor;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_buffered.sv
// tb_uart_buffered: scoreboard bench for uart_buffered.
// Bus reads push their expected value into rd_q and a monitor compares it
// whenever read is strobed; expected TX frames go into tx_q and a serial
// monitor checks every bit at both ends of its 16-clock window.
module tb_uart_buffered;
    localparam logic [31:0] A_DATA   = 32'h0000_1000;
    localparam logic [31:0] A_STATUS = 32'h0000_1004;
    localparam logic [31:0] A_CTRL   = 32'h0000_1008;
    localparam logic [31:0] A_DIV    = 32'h0000_100C;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        tx, irq, rx;
    logic        rx_drv = 1'b1;
    logic        loop_en = 1'b0;
    bit          tx_mon_on = 1'b1;

    assign rx = loop_en ? tx : rx_drv;

    typedef struct {
        string       name;
        logic [31:0] value;
    } rd_exp_t;

    typedef struct {
        logic [7:0] data;
        bit         par_en;
        bit         par_bit;
    } tx_exp_t;

    rd_exp_t rd_q[$];
    tx_exp_t tx_q[$];
    int total = 0;
    int bad   = 0;

    uart_buffered dut (
        .clk(clk), .resetn(resetn), .rx(rx), .tx(tx),
        .read(read), .write(write), .address(address),
        .write_data(write_data), .read_data(read_data), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // One bus cycle; for reads the expected value is queued first.
    task automatic applyStimulus(input bit is_read, input logic [31:0] addr,
                                 input logic [31:0] value, input string name);
        rd_exp_t r;
        if (is_read) begin
            r.name  = name;
            r.value = value;
            rd_q.push_back(r);
        end
        @(posedge clk); #1;
        address    = addr;
        read       = is_read;
        write      = !is_read;
        write_data = is_read ? 32'h0 : value;
        @(posedge clk); #1;
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] data, input bit has_par,
                              input bit par_bit, input bit stop_bit);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = data[i];
            repeat (16) @(negedge clk);
        end
        if (has_par) begin
            rx_drv = par_bit;
            repeat (16) @(negedge clk);
        end
        rx_drv = stop_bit;
        repeat (16) @(negedge clk);
        rx_drv = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    function automatic tx_exp_t tx_frame(input logic [7:0] d, input bit pe, input bit pb);
        tx_exp_t e;
        e.data    = d;
        e.par_en  = pe;
        e.par_bit = pb;
        return e;
    endfunction

    initial begin : read_monitor
        rd_exp_t r;
        forever begin
            @(negedge clk);
            if (read) begin
                if (rd_q.size() == 0) checkOutput("rd_unexpected", 32'(rd_q.size()), 32'd1);
                else begin
                    r = rd_q.pop_front();
                    checkOutput(r.name, read_data, r.value);
                end
            end
        end
    end

    initial begin : tx_monitor
        tx_exp_t    e;
        logic [11:0] exp_bits, obs_a, obs_b;
        int          nbits;
        forever begin
            @(negedge clk);
            if (tx_mon_on && resetn && tx === 1'b0) begin
                if (tx_q.size() == 0) begin
                    checkOutput("tx_unexpected_frame", 32'(tx_q.size()), 32'd1);
                    repeat (200) @(negedge clk);
                end else begin
                    e = tx_q.pop_front();
                    exp_bits      = '0;
                    exp_bits[8:1] = e.data;
                    nbits         = 9;
                    if (e.par_en) begin
                        exp_bits[9] = e.par_bit;
                        nbits       = 10;
                    end
                    exp_bits[nbits] = 1'b1;
                    nbits++;
                    obs_a    = '0;
                    obs_b    = '0;
                    obs_a[0] = tx;
                    for (int j = 1; j <= 16 * nbits - 1; j++) begin
                        @(negedge clk);
                        if (j % 16 == 0)  obs_a[j / 16] = tx;
                        if (j % 16 == 15) obs_b[j / 16] = tx;
                    end
                    checkOutput("tx_frame_bit_first_clk", 32'(obs_a), 32'(exp_bits));
                    checkOutput("tx_frame_bit_last_clk", 32'(obs_b), 32'(exp_bits));
                end
            end
        end
    end

    initial begin : main
        repeat (3) @(negedge clk);
        checkOutput("reset_tx", 32'(tx), 32'd1);
        checkOutput("reset_irq", 32'(irq), 32'd0);
        resetn = 1'b1;

        applyStimulus(1, A_STATUS, 32'h004, "reset_status");
        applyStimulus(1, A_CTRL, 32'h03, "reset_ctrl");
        applyStimulus(1, A_DIV, 32'd2604, "reset_divisor");

        applyStimulus(0, A_DIV, 32'd5, "");
        applyStimulus(1, A_DIV, 32'd16, "divisor_clamp");
        applyStimulus(0, A_DIV, 32'd16, "");

        $display("[TB] transmit 0x55");
        tx_q.push_back(tx_frame(8'h55, 1'b0, 1'b0));
        applyStimulus(0, A_DATA, 32'h55, "");
        repeat (200) @(negedge clk);
        applyStimulus(1, A_STATUS, 32'h004, "tx_done_status");
        applyStimulus(0, A_CTRL, 32'h43, "");
        repeat (3) @(negedge clk);
        checkOutput("irq_tx_ie", 32'(irq), 32'd1);
        applyStimulus(0, A_CTRL, 32'h03, "");

        $display("[TB] loopback odd parity 0xA3");
        loop_en = 1'b1;
        applyStimulus(0, A_CTRL, 32'h0F, "");
        tx_q.push_back(tx_frame(8'hA3, 1'b1, 1'b1));
        applyStimulus(0, A_DATA, 32'hA3, "");
        repeat (250) @(negedge clk);
        applyStimulus(1, A_STATUS, 32'h005, "loop_status");
        applyStimulus(1, A_DATA, 32'hA3, "loop_data");
        applyStimulus(1, A_STATUS, 32'h004, "loop_drained");
        loop_en = 1'b0;
        applyStimulus(0, A_CTRL, 32'h03, "");

        $display("[TB] TX FIFO overflow");
        applyStimulus(0, A_CTRL, 32'h02, "");
        for (int i = 0; i < 9; i++) begin
            if (i < 8) tx_q.push_back(tx_frame(8'(8'h10 + i), 1'b0, 1'b0));
            applyStimulus(0, A_DATA, 32'(32'h10 + i), "");
        end
        applyStimulus(1, A_STATUS, 32'h108, "tx_full_ovf");
        applyStimulus(0, A_STATUS, 32'h100, "");
        applyStimulus(1, A_STATUS, 32'h008, "tx_ovf_clear");
        applyStimulus(0, A_CTRL, 32'h03, "");
        repeat (1500) @(negedge clk);
        applyStimulus(1, A_STATUS, 32'h004, "tx_drain");

        $display("[TB] RX FIFO overflow");
        for (int i = 0; i < 9; i++) send_frame(8'(8'h61 + i), 1'b0, 1'b0, 1'b1);
        applyStimulus(1, A_STATUS, 32'h027, "rx_full_ovf");
        checkOutput("irq_rx_ovf", 32'(irq), 32'd1);
        for (int i = 0; i < 8; i++) applyStimulus(1, A_DATA, 32'(32'h61 + i), "rx_fifo_order");
        applyStimulus(1, A_STATUS, 32'h024, "rx_drained");
        applyStimulus(0, A_STATUS, 32'h020, "");
        repeat (3) @(negedge clk);
        checkOutput("irq_cleared", 32'(irq), 32'd0);
        applyStimulus(1, A_STATUS, 32'h004, "rx_ovf_clear");

        $display("[TB] framing error and glitch");
        send_frame(8'h41, 1'b0, 1'b0, 1'b0);
        applyStimulus(1, A_STATUS, 32'h044, "frame_err");
        checkOutput("irq_frame_err", 32'(irq), 32'd1);
        applyStimulus(1, A_DATA, 32'h0, "frame_err_discard");
        applyStimulus(0, A_STATUS, 32'h040, "");
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (8) @(negedge clk);
        rx_drv = 1'b1;
        repeat (200) @(negedge clk);
        applyStimulus(1, A_STATUS, 32'h004, "glitch_reject");
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        applyStimulus(1, A_DATA, 32'h5A, "rearm_data");

        $display("[TB] parity error");
        applyStimulus(0, A_CTRL, 32'h07, "");
        send_frame(8'h03, 1'b1, 1'b1, 1'b1);
        applyStimulus(1, A_STATUS, 32'h084, "parity_err");
        applyStimulus(0, A_STATUS, 32'h080, "");
        applyStimulus(0, A_CTRL, 32'h03, "");
        applyStimulus(1, A_STATUS, 32'h004, "parity_clear");

        $display("[TB] reset mid-frame");
        applyStimulus(0, A_CTRL, 32'h23, "");
        send_frame(8'h33, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("irq_rx_ie", 32'(irq), 32'd1);
        tx_mon_on = 1'b0;
        applyStimulus(0, A_DATA, 32'h00, "");
        repeat (50) @(negedge clk);
        checkOutput("tx_mid_frame", 32'(tx), 32'd0);
        resetn = 1'b0;
        #1;
        checkOutput("reset_tx_async", 32'(tx), 32'd1);
        checkOutput("reset_irq_async", 32'(irq), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        applyStimulus(1, A_STATUS, 32'h004, "post_reset_status");
        applyStimulus(1, A_CTRL, 32'h03, "post_reset_ctrl");
        applyStimulus(1, A_DIV, 32'd2604, "post_reset_divisor");

        repeat (20) @(negedge clk);
        checkOutput("tx_pending", 32'(tx_q.size()), 32'd0);
        checkOutput("rd_pending", 32'(rd_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_buffered.md
UART_BUFFERED -- requirements
Module: uart_buffered

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 25000000, system clock in Hz.
REQ-002 SHALL have parameter BIT_RATE, default 9600, reset baud rate; reset divisor = CLOCK_FREQ/BIT_RATE.
REQ-003 SHALL have parameter PAYLOAD_BITS, default 8, data bits per frame (5..8).
REQ-004 SHALL have parameter BUFFER_SIZE, default 8, depth of each of TX and RX FIFO (power of two, >=2).
REQ-005 SHALL have parameter BASE_ADDRESS, default 32'h00001000, word-aligned base of a 4-word register window.
REQ-006 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-007 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port rx, input, 1, serial receive line, idle high, asynchronous to clk.
REQ-009 SHALL have port tx, output, 1, serial transmit line, idle high.
REQ-010 SHALL have ports read and write, input, 1 each, single-cycle bus strobes.
REQ-011 SHALL have ports address and write_data, input, 32 each; read_data, output, 32.
REQ-012 SHALL have port irq, output, 1, level interrupt request.

Function
REQ-013 SHALL decode address[31:4]==BASE_ADDRESS[31:4]; offsets 0x0 DATA, 0x4 STATUS, 0x8 CTRL, 0xC DIVISOR; unselected access ignored, read_data=0.
REQ-014 SHALL drive read_data combinationally during read; zero-extend all fields; 0 when read low.
REQ-015 DATA write SHALL push write_data[PAYLOAD_BITS-1:0] into TX FIFO; write when full SHALL be dropped and set sticky TX_OVF.
REQ-016 DATA read SHALL return RX FIFO head and pop it that cycle; read when empty SHALL return 0, no pop.
REQ-017 STATUS bits SHALL be: 0 RX_NOT_EMPTY, 1 RX_FULL, 2 TX_EMPTY, 3 TX_FULL, 4 TX_BUSY, 5 RX_OVF, 6 FRAME_ERR, 7 PARITY_ERR, 8 TX_OVF.
REQ-018 Writing 1 to STATUS bits 5..8 SHALL clear them; a set event in the same cycle SHALL win.
REQ-019 CTRL bits SHALL be: 0 TX_EN, 1 RX_EN, 2 PAR_EN, 3 PAR_ODD, 4 STOP2, 5 RX_IE, 6 TX_IE; read-write.
REQ-020 DIVISOR[15:0] SHALL hold clocks per bit; writes below 16 SHALL be clamped to 16; change takes effect at next frame start.
REQ-021 TX FSM SHALL have states IDLE, START, DATA, PARITY, STOP; frame = start(0), data LSB first, optional parity, 1 or 2 stop bits, each DIVISOR clocks.
REQ-022 TX SHALL leave IDLE the cycle after TX FIFO non-empty and TX_EN=1, popping the head; clearing TX_EN mid-frame SHALL finish the current frame.
REQ-023 Parity SHALL be XOR of data bits, inverted when PAR_ODD.
REQ-024 rx SHALL pass a 2-flop synchronizer before use.
REQ-025 RX FSM SHALL have states IDLE, START, DATA, PARITY, STOP; falling edge in IDLE with RX_EN=1 enters START.
REQ-026 RX SHALL sample at DIVISOR/2 into each bit; start sample high SHALL return to IDLE without error (glitch reject).
REQ-027 Stop sample low SHALL set FRAME_ERR, discard byte, and wait for rx high before re-arming; parity mismatch SHALL set PARITY_ERR and discard byte.
REQ-028 Valid byte with RX FIFO full SHALL be dropped and set RX_OVF; FIFO contents unchanged.
REQ-029 Simultaneous FIFO push and pop SHALL both occur, count unchanged, including at full (pop frees slot) and empty (push only).
REQ-030 FIFO pointers SHALL wrap modulo BUFFER_SIZE; occupancy counter width clog2(BUFFER_SIZE)+1.
REQ-031 irq SHALL equal (RX_IE & RX_NOT_EMPTY) | (TX_IE & TX_EMPTY & ~TX_BUSY) | RX_OVF | FRAME_ERR | PARITY_ERR, registered.

Reset
REQ-032 resetn low SHALL immediately force tx=1, irq=0, both FIFOs empty, FSMs IDLE, all STATUS flags 0, CTRL=8'h03, DIVISOR=CLOCK_FREQ/BIT_RATE.
REQ-033 Reset mid-frame SHALL abort the frame; no partial byte enters RX FIFO; tx returns high asynchronously.

Verification
REQ-034 DIVISOR=16, write DATA 0x55 -> tx low 16 clk, then 1,0,1,0,1,0,1,0 each 16 clk, stop high; TX_EMPTY=1 after.
REQ-035 Loop tx->rx, PAR_EN=1 PAR_ODD=1, send 0xA3 -> parity bit 1; DATA read returns 0xA3; RX_NOT_EMPTY then 0.
REQ-036 Write 9 bytes with TX_EN=0, BUFFER_SIZE=8 -> TX_FULL=1, TX_OVF=1, 9th byte never transmitted; write STATUS 0x100 -> TX_OVF=0.
REQ-037 Drive 9 frames into rx without reading -> RX_FULL=1, RX_OVF=1, irq=1; 8 reads return first 8 bytes in order.
REQ-038 Drive frame 0x41 with stop bit low -> FRAME_ERR=1, RX FIFO empty; 8-clk low glitch on rx -> no state change.
REQ-039 Assert resetn low mid-transmission -> tx=1 same cycle, STATUS=0x004, CTRL=0x03.
